// File: rtl/acc_pkg.sv
// Shared constants and types for the current-block memory sequencer.
package acc_pkg;

    localparam int unsigned IMG_W  = 16;
    localparam int unsigned IMG_H  = 16;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned NPIX   = IMG_W * IMG_H;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_LOAD,
        CTRL_STREAM
    } ctrl_state_e;

endpackage

// File: rtl/curr_mem_addr_gen.sv
// Read-side scan address generator: row/col counters producing the memory
// address and a last-pixel flag. Scan order is raster by default; defining
// CURR_MEM_CTRL_COL_SCAN_EN switches to column-major (row fastest).
module curr_mem_addr_gen
    import acc_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  adv,
    output addr_t addr,
    output logic  last
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_end;
    logic             row_end;

    assign col_end = (col == COL_W'(IMG_W - 1));
    assign row_end = (row == ROW_W'(IMG_H - 1));
    assign addr    = ADDR_W'({row, col});
    assign last    = row_end && col_end;

    // Advance the scan position; clear has priority over advance.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
`ifdef CURR_MEM_CTRL_COL_SCAN_EN
            if (row_end) begin
                row <= '0;
                col <= col + COL_W'(1);
            end else begin
                row <= row + ROW_W'(1);
            end
`else
            if (col_end) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
`endif
        end
    end

endmodule

// File: rtl/curr_mem_ctrl.sv
// Current-block memory sequencer: LOAD writes a 256-pixel raster stream into
// the block memory, STREAM scans it out to the compute datapath.
// Optional column-major STREAM order via CURR_MEM_CTRL_COL_SCAN_EN.
module curr_mem_ctrl
    import acc_pkg::*;
#(
    parameter bit INIT_LOADED = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic              stream_start_i,
    input  logic              in_valid_i,
    input  logic [PIX_W-1:0]  in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [PIX_W-1:0]  mem_wdata_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [PIX_W-1:0]  mem_rdata_i,
    output logic              out_valid_o,
    output logic [PIX_W-1:0]  out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              loaded_o,
    output logic              done_o
);

    ctrl_state_e state;
    ctrl_state_e state_nxt;
    addr_t       wcnt;
    addr_t       rd_addr;
    logic        rd_last;
    logic        load_enter;
    logic        wr_fire;
    logic        wr_final;
    logic        rd_fire;
    logic        rd_final;

    assign load_enter  = (state == CTRL_IDLE) && load_start_i;
    assign mem_waddr_o = wcnt;
    assign mem_wdata_o = in_data_i;
    assign mem_raddr_o = rd_addr;
    assign out_data_o  = mem_rdata_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= CTRL_IDLE;
        else       state <= state_nxt;
    end

    // Next-state selection; LOAD request wins over STREAM.
    always_comb begin
        state_nxt = state;
        case (state)
            CTRL_IDLE: begin
                if (load_start_i)                    state_nxt = CTRL_LOAD;
                else if (stream_start_i && loaded_o) state_nxt = CTRL_STREAM;
            end
            CTRL_LOAD:   if (wr_final) state_nxt = CTRL_IDLE;
            CTRL_STREAM: if (rd_final) state_nxt = CTRL_IDLE;
            default:     state_nxt = CTRL_IDLE;
        endcase
    end

    // Handshake and memory-port outputs decoded from the current state.
    always_comb begin
        in_ready_o  = 1'b0;
        mem_we_o    = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        busy_o      = 1'b0;
        wr_fire     = 1'b0;
        wr_final    = 1'b0;
        rd_fire     = 1'b0;
        rd_final    = 1'b0;
        case (state)
            CTRL_LOAD: begin
                busy_o     = 1'b1;
                in_ready_o = 1'b1;
                mem_we_o   = in_valid_i;
                wr_fire    = in_valid_i;
                wr_final   = in_valid_i && (wcnt == ADDR_W'(NPIX - 1));
            end
            CTRL_STREAM: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                out_last_o  = rd_last;
                rd_fire     = out_ready_i;
                rd_final    = out_ready_i && rd_last;
            end
            default: ;
        endcase
    end

    // Write counter, loaded flag and completion pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wcnt     <= '0;
            loaded_o <= INIT_LOADED;
            done_o   <= 1'b0;
        end else begin
            done_o <= wr_final || rd_final;
            if (load_enter) begin
                wcnt     <= '0;
                loaded_o <= 1'b0;
            end else if (wr_fire) begin
                wcnt <= wcnt + ADDR_W'(1);
                if (wr_final) loaded_o <= 1'b1;
            end
        end
    end

    curr_mem_addr_gen u_addr_gen (
        .clk  (clk_i),
        .rst  (rst_i),
        .clr  (rd_final),
        .adv  (rd_fire),
        .addr (rd_addr),
        .last (rd_last)
    );

endmodule

// File: tb/tb_curr_mem_ctrl.sv
// Scoreboard bench for curr_mem_ctrl with a behavioural async-read memory.
module tb_curr_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       stream_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       loaded;
    logic       done;

    // Second instance with an empty-at-reset memory (outputs mostly unused).
    logic       d0_in_ready, d0_mem_we, d0_out_valid, d0_out_last;
    logic       d0_busy, d0_loaded, d0_done;
    logic [7:0] d0_waddr, d0_wdata, d0_raddr, d0_out_data;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    logic       preload;

    logic [15:0] wr_q[$];
    logic [16:0] rd_q[$];

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    curr_mem_ctrl #(.INIT_LOADED(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst), .load_start_i(load_start), .stream_start_i(stream_start),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .mem_we_o(mem_we), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
        .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
        .out_ready_i(out_ready), .busy_o(busy), .loaded_o(loaded), .done_o(done)
    );

    curr_mem_ctrl #(.INIT_LOADED(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .load_start_i(load_start), .stream_start_i(stream_start),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(d0_in_ready),
        .mem_we_o(d0_mem_we), .mem_waddr_o(d0_waddr), .mem_wdata_o(d0_wdata),
        .mem_raddr_o(d0_raddr), .mem_rdata_i(8'h00),
        .out_valid_o(d0_out_valid), .out_data_o(d0_out_data), .out_last_o(d0_out_last),
        .out_ready_i(out_ready), .busy_o(d0_busy), .loaded_o(d0_loaded), .done_o(d0_done)
    );

    // Behavioural block memory: async read, sync write, preload during reset.
    assign mem_rdata = mem[mem_raddr];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] scan_addr(input int k);
`ifdef CURR_MEM_CTRL_COL_SCAN_EN
        return 8'((k % 16) * 16 + k / 16);
`else
        return 8'(k);
`endif
    endfunction

    // Monitor: pop and compare every write beat and every accepted read beat.
    always @(negedge clk) begin
        logic [15:0] w;
        logic [16:0] r;
        if (!rst && mem_we) begin
            if (wr_q.size() == 0) check("unexpected_write", {8'h0, mem_waddr, mem_wdata}, 32'hFFFF_FFFF);
            else begin
                w = wr_q.pop_front();
                check("waddr", 32'(mem_waddr), 32'(w[15:8]));
                check("wdata", 32'(mem_wdata), 32'(w[7:0]));
            end
        end
        if (!rst && out_valid && out_ready) begin
            if (rd_q.size() == 0) check("unexpected_beat", 32'(mem_raddr), 32'hFFFF_FFFF);
            else begin
                r = rd_q.pop_front();
                check("raddr", 32'(mem_raddr), 32'(r[15:8]));
                check("out_data", 32'(out_data), 32'(r[7:0]));
                check("out_last", 32'(out_last), 32'(r[16]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream();
        logic [7:0] a;
        for (int k = 0; k < 256; k++) begin
            a = scan_addr(k);
            rd_q.push_back({(k == 255), a, exp_mem[a]});
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
    endtask

    // Feed n pixels (value = index ^ xv) with ~50% valid; optional stream poke early on.
    task automatic feed(input int n, input logic [7:0] xv, input bit poke);
        int i;
        logic v;
        i = 0;
        while (i < n) begin
            v = 1'($urandom_range(0, 1));
            stream_start = poke && (i < 20);
            in_valid = v;
            in_data  = 8'(i) ^ xv;
            if (v) begin
                wr_q.push_back({8'(i), 8'(i) ^ xv});
                exp_mem[i] = 8'(i) ^ xv;
            end
            tick();
            if (v) i++;
            if (i < n) check("in_ready_load", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        stream_start = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; preload = 1'b1;
        load_start = 1'b0; stream_start = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 7 + 3);
        tick(); tick();
        rst = 1'b0; preload = 1'b0;
        tick();

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_loaded", 32'(loaded), 32'd1);
        check("rst_loaded_init0", 32'(d0_loaded), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_raddr", 32'(mem_raddr), 32'd0);

        // Stream preloaded block at full throughput
        push_stream();
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        check("stream_busy", 32'(busy), 32'd1);
        check("ignored_stream_unloaded", 32'(d0_busy), 32'd0);
        wait_done(n);
        check("stream_cycles", 32'(n), 32'd256);
        check("stream_idle", 32'(busy), 32'd0);
        check("stream_loaded", 32'(loaded), 32'd1);
        check("rd_q_empty1", 32'(rd_q.size()), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);

        // Load with 50% valid, stream starts during LOAD ignored
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_clears_loaded", 32'(loaded), 32'd0);
        feed(256, 8'hA5, 1'b1);
        check("load_done", 32'(done), 32'd1);
        check("load_loaded", 32'(loaded), 32'd1);
        check("load_idle", 32'(busy), 32'd0);
        check("wr_q_empty1", 32'(wr_q.size()), 32'd0);
        tick();
        check("load_done_pulse", 32'(done), 32'd0);

        // Stream back with a 5-cycle stall at beat 17
        push_stream();
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        for (int k = 0; k < 17; k++) tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_raddr", 32'(mem_raddr), 32'(scan_addr(17)));
            check("stall_data", 32'(out_data), 32'(exp_mem[scan_addr(17)]));
            tick();
        end
        out_ready = 1'b1;
        wait_done(n);
        check("stall_cycles", 32'(n), 32'd239);
        check("rd_q_empty2", 32'(rd_q.size()), 32'd0);
        tick();

        // Both starts together: LOAD wins; then reset after 100 beats
        load_start = 1'b1; stream_start = 1'b1;
        tick();
        load_start = 1'b0; stream_start = 1'b0;
        check("both_load", 32'(in_ready), 32'd1);
        check("both_not_stream", 32'(out_valid), 32'd0);
        feed(100, 8'h3C, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_loaded", 32'(loaded), 32'd1);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        #1;
        check("abort_no_we", 32'(mem_we), 32'd0);
        in_valid = 1'b0;
        check("wr_q_empty2", 32'(wr_q.size()), 32'd0);
        tick();

        // Fresh load restarts at address 0, then verify by streaming
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        feed(256, 8'h5A, 1'b0);
        check("reload_done", 32'(done), 32'd1);
        tick();
        push_stream();
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        wait_done(n);
        check("final_cycles", 32'(n), 32'd256);
        check("rd_q_empty3", 32'(rd_q.size()), 32'd0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
